shifter_seq_nb: RTL and testbench
=================================

SHIFTER_SEQ_NB -- requirements
Module: shifter_seq_nb

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits (legal 2..64).
REQ-002 Parameter STEP, default 2, maximum bits shifted per clock (legal 1..WIDTH).
REQ-003 Localparam AW = clog2(WIDTH), shift-amount width.
REQ-004 One clock; reset is asynchronous and active-low, ports i_clk and i_clr_.
REQ-005 i_clk  input  1  clock, all state updates on rising edge.
REQ-006 i_clr_  input  1  asynchronous active-low clear.
REQ-007 i_start  input  1  request pulse, sampled only in IDLE.
REQ-008 i_data  input  WIDTH  operand, captured at accepted start.
REQ-009 i_amt  input  AW  shift amount 0..WIDTH-1, captured at accepted start.
REQ-010 i_leftRight  input  1  direction, 0 = left, 1 = right, captured at start.
REQ-011 i_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 serial-fill; captured at start.
REQ-012 i_bit  input  1  fill bit for serial-fill mode, captured at start.
REQ-013 o_data  output  WIDTH  working/result register.
REQ-014 o_busy  output  1  high while in SHIFT.
REQ-015 o_done  output  1  high for exactly one cycle in DONE.
REQ-016 o_carry  output  1  last bit shifted (or rotated) out; 0 when amount is 0.

Function
REQ-017 FSM states IDLE, SHIFT, DONE shall exist; reset state IDLE.
REQ-018 IDLE with i_start=1 at edge k: load i_data, mode, direction, fill bit, remaining=i_amt, carry=0; next state SHIFT if i_amt>0, else DONE.
REQ-019 Each SHIFT edge shifts o_data by n=min(STEP, remaining) and decrements remaining by n; when remaining reaches 0 next state DONE.
REQ-020 Result becomes valid at edge k+ceil(amt/STEP) and is held in DONE and IDLE until the next accepted start.
REQ-021 DONE lasts one cycle, then IDLE unconditionally.
REQ-022 i_start in SHIFT or DONE shall be ignored, with no queuing.
REQ-023 Logical: vacated positions filled with 0.
REQ-024 Arithmetic right: vacated positions filled with the captured MSB; arithmetic left identical to logical left.
REQ-025 Rotate: bits leaving one end re-enter at the other.
REQ-026 Serial-fill: vacated positions filled with captured i_bit.
REQ-027 o_carry updated each SHIFT edge to the last bit leaving the word in that step (for rotate, the last bit that wrapped).
REQ-028 Inputs other than i_start/i_clr_ are don't-care outside the accepting edge.

Reset
REQ-029 i_clr_ low asynchronously forces state IDLE, o_data=0, o_carry=0, remaining=0, o_busy=0, o_done=0, including mid-operation.
REQ-030 First start accepted at the first rising edge with i_clr_ high.

Configuration
REQ-031 With SHIFTER_SEQ_STICKY_EN defined: output o_sticky (1 bit) = OR of all bits shifted out since the last accepted start, cleared at start and reset, held after DONE; always 0 in rotate mode.
REQ-032 Without SHIFTER_SEQ_STICKY_EN: port o_sticky and its logic are absent; all other behaviour identical.

Structure
REQ-033 Package shifter_pkg holds the mode encodings (MODE_LOGIC, MODE_ARITH, MODE_ROT, MODE_FILL) and the FSM state encodings.
REQ-034 One sub-module shift_step (combinational: data, count 0..STEP, direction, mode, fill bit -> next data, carry-out, sticky-out) instantiated once.

Verification
REQ-035 WIDTH=8, STEP=2: 0x96, right, arithmetic, amt 3 -> o_data=0xF2, o_carry=1, busy for 2 cycles, o_done one cycle after the 2nd shift edge.
REQ-036 WIDTH=8, STEP=2: 0x81, left, rotate, amt 1 -> o_data=0x03, o_carry=1, single SHIFT cycle.
REQ-037 WIDTH=8, STEP=2: 0xFF, left, logical, amt 7 -> o_data=0x80, o_carry=1 after 4 shift edges; i_start pulsed mid-shift is ignored.
REQ-038 amt 0, 0x5A -> DONE directly at the next cycle, o_data=0x5A, o_carry=0, o_busy never high.
REQ-039 STICKY_EN: 0x96 right logical amt 3 -> 0x12, o_sticky=1; 0x90 same -> 0x12, o_sticky=0.
REQ-040 i_clr_ low during SHIFT -> immediate IDLE, all outputs 0; next start completes normally.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared encodings for the sequential barrel-less shifter: operation modes and FSM states.
package shifter_pkg;

  typedef enum logic [1:0] {
    MODE_LOGIC = 2'b00,
    MODE_ARITH = 2'b01,
    MODE_ROT   = 2'b10,
    MODE_FILL  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shifter_seq_nb_shift_step.sv
// Combinational single-step shifter: moves data by 0..STEP positions in one cycle,
// reporting the last bit to leave the word and the OR of everything that left it.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 2,
  localparam int CW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [CW-1:0]    count,
  input  logic             right,
  input  mode_e            mode,
  input  logic             fill_bit,
  output logic [WIDTH-1:0] data_next,
  output logic             carry,
  output logic             sticky
);

  logic in_bit;
  logic out_bit;

  // Unrolled one-bit moves; carry ends up holding the bit from the final move.
  always_comb begin
    data_next = data;
    carry     = 1'b0;
    sticky    = 1'b0;
    in_bit    = 1'b0;
    out_bit   = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(count)) begin
        out_bit = right ? data_next[0] : data_next[WIDTH-1];
        case (mode)
          MODE_ROT:   in_bit = out_bit;
          MODE_FILL:  in_bit = fill_bit;
          MODE_ARITH: in_bit = right & fill_bit;
          default:    in_bit = 1'b0;
        endcase
        data_next = right ? {in_bit, data_next[WIDTH-1:1]}
                          : {data_next[WIDTH-2:0], in_bit};
        carry = out_bit;
        if (mode != MODE_ROT) sticky = sticky | out_bit;
      end
    end
  end

endmodule

// File: rtl/shifter_seq_nb.sv
// Multi-cycle shifter moving up to STEP bits per clock; result valid ceil(amt/STEP) edges after start.
// Optional o_sticky output (OR of shifted-out bits) enabled by defining SHIFTER_SEQ_STICKY_EN.
module shifter_seq_nb
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 2,
  localparam int AW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_clr_,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_data,
  input  logic [AW-1:0]    i_amt,
  input  logic             i_leftRight,
  input  logic [1:0]       i_mode,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_carry
`ifdef SHIFTER_SEQ_STICKY_EN
  , output logic           o_sticky
`endif
);

  localparam int CW = $clog2(STEP + 1);

  state_e           state;
  state_e           state_nxt;
  logic [AW-1:0]    remaining;
  mode_e            mode_q;
  logic             right_q;
  logic             fill_q;
  logic [CW-1:0]    n;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;
  logic             step_sticky;

  always_comb begin
    if (int'(remaining) > STEP) n = CW'(STEP);
    else                        n = CW'(remaining);
  end

  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .data      (o_data),
    .count     (n),
    .right     (right_q),
    .mode      (mode_q),
    .fill_bit  (fill_q),
    .data_next (step_data),
    .carry     (step_carry),
    .sticky    (step_sticky)
  );

  always_ff @(posedge i_clk or negedge i_clr_) begin
    if (!i_clr_) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = (i_amt != '0) ? SHIFT : DONE;
      SHIFT:   if (remaining == AW'(n)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // fill_q carries the sign bit for arithmetic mode so the step only needs one fill source.
  always_ff @(posedge i_clk or negedge i_clr_) begin
    if (!i_clr_) begin
      o_data    <= '0;
      o_carry   <= 1'b0;
      remaining <= '0;
      mode_q    <= MODE_LOGIC;
      right_q   <= 1'b0;
      fill_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          o_data    <= i_data;
          o_carry   <= 1'b0;
          remaining <= i_amt;
          mode_q    <= mode_e'(i_mode);
          right_q   <= i_leftRight;
          fill_q    <= (mode_e'(i_mode) == MODE_ARITH) ? i_data[WIDTH-1] : i_bit;
        end
        SHIFT: begin
          o_data    <= step_data;
          o_carry   <= step_carry;
          remaining <= remaining - AW'(n);
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state == SHIFT);
  assign o_done = (state == DONE);

`ifdef SHIFTER_SEQ_STICKY_EN
  always_ff @(posedge i_clk or negedge i_clr_) begin
    if (!i_clr_)                     o_sticky <= 1'b0;
    else if (state == IDLE && i_start) o_sticky <= 1'b0;
    else if (state == SHIFT)         o_sticky <= o_sticky | step_sticky;
  end
`else
  logic unused_sticky;
  assign unused_sticky = step_sticky;
`endif

endmodule

// File: tb/tb_shifter_seq_nb.sv
// Scoreboard bench for shifter_seq_nb at WIDTH=8, STEP=2: a whole-word reference model predicts each result.
module tb_shifter_seq_nb;
  import shifter_pkg::*;

  localparam int WIDTH = 8;
  localparam int STEP  = 2;
  localparam int AW    = 3;

  logic             clk   = 1'b0;
  logic             clr_  = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] data  = '0;
  logic [AW-1:0]    amt   = '0;
  logic             lr    = 1'b0;
  logic [1:0]       mode  = 2'b00;
  logic             fbit  = 1'b0;
  logic [WIDTH-1:0] o_data;
  logic             o_busy;
  logic             o_done;
  logic             o_carry;
`ifdef SHIFTER_SEQ_STICKY_EN
  logic             o_sticky;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       carry;
    logic       sticky;
    int         cycles;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  shifter_seq_nb #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .i_clk       (clk),
    .i_clr_      (clr_),
    .i_start     (start),
    .i_data      (data),
    .i_amt       (amt),
    .i_leftRight (lr),
    .i_mode      (mode),
    .i_bit       (fbit),
    .o_data      (o_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_carry     (o_carry)
`ifdef SHIFTER_SEQ_STICKY_EN
    , .o_sticky  (o_sticky)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [7:0] d, input int n, input logic right,
                                 input logic [1:0] m, input logic b);
    exp_t       e;
    logic [7:0] ones;
    logic [7:0] mask;
    logic [7:0] lo;
    ones     = 8'hFF;
    e.data   = d;
    e.carry  = 1'b0;
    e.sticky = 1'b0;
    e.cycles = (n + STEP - 1) / STEP;
    if (n > 0) begin
      if (!right) begin
        mask     = ~(ones << n);
        e.carry  = d[8-n];
        e.sticky = (m != 2'b10) && (|(d >> (8 - n)));
        case (m)
          2'b10:   e.data = (d << n) | (d >> (8 - n));
          2'b11:   e.data = (d << n) | (b ? mask : 8'h00);
          default: e.data = d << n;
        endcase
      end else begin
        mask     = ~(ones >> n);
        lo       = ~(ones << n);
        e.carry  = d[n-1];
        e.sticky = (m != 2'b10) && (|(d & lo));
        case (m)
          2'b01:   e.data = 8'($signed(d) >>> n);
          2'b10:   e.data = (d >> n) | (d << (8 - n));
          2'b11:   e.data = (d >> n) | (b ? mask : 8'h00);
          default: e.data = d >> n;
        endcase
      end
    end
    return e;
  endfunction

  task automatic run_op(input logic [7:0] d, input int a, input logic r, input logic [1:0] m,
                        input logic b, input bit poke, input int abort_at);
    exp_t e;
    int   busy_cnt;
    bit   seen;
    busy_cnt = 0;
    seen     = 1'b0;
    @(negedge clk);
    data  = d;
    amt   = AW'(a);
    lr    = r;
    mode  = m;
    fbit  = b;
    start = 1'b1;
    sb.push_back(model(d, a, r, m, b));
    @(negedge clk);
    start = 1'b0;
    data  = 8'($urandom);
    amt   = 3'($urandom);
    lr    = 1'($urandom);
    mode  = 2'($urandom);
    fbit  = 1'($urandom);
    for (int t = 0; t < 40; t++) begin
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      if (o_busy) busy_cnt++;
      if (abort_at > 0 && busy_cnt == abort_at) begin
        #1 clr_ = 1'b0;
        #1;
        check("clr_data", o_data, 0);
        check("clr_carry", o_carry, 0);
        check("clr_busy", o_busy, 0);
        check("clr_done", o_done, 0);
`ifdef SHIFTER_SEQ_STICKY_EN
        check("clr_sticky", o_sticky, 0);
`endif
        clr_ = 1'b1;
        e = sb.pop_back();
        return;
      end
      start = poke && (busy_cnt == 1);
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) begin
      check("done_timeout", 0, 1);
      e = sb.pop_front();
      return;
    end
    e = sb.pop_front();
    check("result", o_data, e.data);
    check("carry", o_carry, e.carry);
    check("busy_cycles", busy_cnt, e.cycles);
`ifdef SHIFTER_SEQ_STICKY_EN
    check("sticky", o_sticky, e.sticky);
`endif
    @(negedge clk);
    check("done_one_cycle", o_done, 0);
    check("idle_busy", o_busy, 0);
    check("hold_data", o_data, e.data);
    check("hold_carry", o_carry, e.carry);
  endtask

  initial begin
    clr_ = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data", o_data, 0);
    check("rst_carry", o_carry, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
`ifdef SHIFTER_SEQ_STICKY_EN
    check("rst_sticky", o_sticky, 0);
`endif
    clr_ = 1'b1;

    run_op(8'h96, 3, 1'b1, MODE_ARITH, 1'b0, 1'b0, 0);
    run_op(8'h81, 1, 1'b0, MODE_ROT,   1'b0, 1'b0, 0);
    run_op(8'hFF, 7, 1'b0, MODE_LOGIC, 1'b0, 1'b1, 0);
    run_op(8'h5A, 0, 1'b1, MODE_FILL,  1'b1, 1'b0, 0);
    run_op(8'h96, 3, 1'b1, MODE_LOGIC, 1'b0, 1'b0, 0);
    run_op(8'h90, 3, 1'b1, MODE_LOGIC, 1'b0, 1'b0, 0);
    run_op(8'hA5, 7, 1'b1, MODE_LOGIC, 1'b0, 1'b0, 2);
    run_op(8'h3C, 5, 1'b1, MODE_FILL,  1'b1, 1'b0, 0);
    run_op(8'h81, 6, 1'b0, MODE_ARITH, 1'b0, 1'b0, 0);
    run_op(8'hC3, 7, 1'b1, MODE_ROT,   1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(8'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
             2'($urandom), 1'($urandom), 1'b0, 0);
    end

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
